el2_lsu_dccm_arb: RTL and testbench

EL2_LSU_DCCM_ARB -- requirements
Module: el2_lsu_dccm_arb

---
 rtl/el2_lsu_dccm_arb_pkg.sv | 12 +
 rtl/el2_lsu_dccm_arb_fifo.sv | 53 +++++
 rtl/el2_lsu_dccm_arb.sv | 150 +++++++++++++++
 tb/tb_el2_lsu_dccm_arb.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/el2_lsu_dccm_arb_pkg.sv
// Shared types and defaults for the LSU DCCM arbiter.
// Read-response ownership lives here so the FIFO, top and benches agree on it.
package el2_lsu_dccm_arb_pkg;

  typedef enum logic {
    CORE = 1'b0,
    DMA  = 1'b1
  } rd_owner_e;

  localparam int DMA_STARVE_MAX_DEF = 4;

endpackage

// File: rtl/el2_lsu_dccm_arb_fifo.sv
// Two-entry DMA request queue with registered storage.
// Pushes are ignored when full and pops are ignored when empty.
module el2_lsu_dccm_arb_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] mem_q [2];
  logic         wptr_q, rptr_q;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_push, do_pop;

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rptr_q];

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= din_i;
        wptr_q        <= ~wptr_q;
      end
      if (do_pop) rptr_q <= ~rptr_q;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/el2_lsu_dccm_arb.sv
// Arbitrates LSU core and queued DMA accesses onto the DCCM port and
// routes one-cycle-latency read data back to whichever side issued the read.
module el2_lsu_dccm_arb
  import el2_lsu_dccm_arb_pkg::*;
#(
  parameter int DCCM_BITS        = 16,
  parameter int DCCM_FDATA_WIDTH = 39,
  parameter int DCCM_BANK_BITS   = 2,
  parameter int DMA_STARVE_MAX   = DMA_STARVE_MAX_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        core_req_valid,
  input  logic                        core_req_wr,
  input  logic [DCCM_BITS-1:0]        core_addr_lo,
  input  logic [DCCM_BITS-1:0]        core_addr_hi,
  input  logic [DCCM_FDATA_WIDTH-1:0] core_wr_data_lo,
  input  logic [DCCM_FDATA_WIDTH-1:0] core_wr_data_hi,
  output logic                        core_req_ready,
  input  logic                        dma_req_valid,
  input  logic                        dma_req_wr,
  input  logic [DCCM_BITS-1:0]        dma_addr,
  input  logic [DCCM_FDATA_WIDTH-1:0] dma_wr_data,
  output logic                        dma_req_ready,
  output logic                        dccm_wren,
  output logic                        dccm_rden,
  output logic [DCCM_BITS-1:0]        dccm_wr_addr_lo,
  output logic [DCCM_BITS-1:0]        dccm_wr_addr_hi,
  output logic [DCCM_BITS-1:0]        dccm_rd_addr_lo,
  output logic [DCCM_BITS-1:0]        dccm_rd_addr_hi,
  output logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_lo,
  output logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_hi,
  input  logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data_lo,
  input  logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data_hi,
  output logic                        core_rd_valid,
  output logic [DCCM_FDATA_WIDTH-1:0] core_rd_data_lo,
  output logic [DCCM_FDATA_WIDTH-1:0] core_rd_data_hi,
  output logic                        dma_rd_valid,
  output logic [DCCM_FDATA_WIDTH-1:0] dma_rd_data
);

  localparam int EW = 1 + DCCM_BITS + DCCM_FDATA_WIDTH;
  localparam int SW = $clog2(DMA_STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(DMA_STARVE_MAX);

  // Bank select sits at [2 +: DCCM_BANK_BITS] and must fit inside the address.
  if (DCCM_BANK_BITS + 2 > DCCM_BITS) begin : g_bad_cfg
    $error("DCCM_BANK_BITS does not fit in DCCM_BITS");
  end

  logic                        fifo_full, fifo_empty;
  logic [EW-1:0]               fifo_din, fifo_head;
  logic                        head_wr;
  logic [DCCM_BITS-1:0]        head_addr;
  logic [DCCM_FDATA_WIDTH-1:0] head_data;
  logic                        dma_pri, grant_core, grant_dma;
  logic [SW-1:0]               starve_q, starve_d;
  logic                        rd_pend_q, rd_pend_d;
  rd_owner_e                   rd_owner_q, rd_owner_d;

  assign fifo_din = {dma_req_wr, dma_addr, dma_wr_data};
  assign {head_wr, head_addr, head_data} = fifo_head;
  assign dma_req_ready = ~fifo_full;

  el2_lsu_dccm_arb_fifo #(.W(EW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (dma_req_valid & dma_req_ready),
    .pop_i   (grant_dma),
    .din_i   (fifo_din),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign dma_pri        = (starve_q == STARVE_MAX);
  assign grant_dma      = ~fifo_empty & (dma_pri | ~core_req_valid);
  assign grant_core     = core_req_valid & ~grant_dma;
  assign core_req_ready = grant_core;

  always_comb begin
    starve_d = starve_q;
    if (grant_dma)
      starve_d = '0;
    else if (grant_core && !fifo_empty && starve_q != STARVE_MAX)
      starve_d = starve_q + SW'(1);
  end

  always_comb begin
    dccm_wren       = 1'b0;
    dccm_rden       = 1'b0;
    dccm_wr_addr_lo = '0;
    dccm_wr_addr_hi = '0;
    dccm_rd_addr_lo = '0;
    dccm_rd_addr_hi = '0;
    dccm_wr_data_lo = '0;
    dccm_wr_data_hi = '0;
    if (grant_core) begin
      if (core_req_wr) begin
        dccm_wren       = 1'b1;
        dccm_wr_addr_lo = core_addr_lo;
        dccm_wr_addr_hi = core_addr_hi;
        dccm_wr_data_lo = core_wr_data_lo;
        dccm_wr_data_hi = core_wr_data_hi;
      end else begin
        dccm_rden       = 1'b1;
        dccm_rd_addr_lo = core_addr_lo;
        dccm_rd_addr_hi = core_addr_hi;
      end
    end else if (grant_dma) begin
      // DMA is always aligned, so both halves see the same address.
      if (head_wr) begin
        dccm_wren       = 1'b1;
        dccm_wr_addr_lo = head_addr;
        dccm_wr_addr_hi = head_addr;
        dccm_wr_data_lo = head_data;
        dccm_wr_data_hi = head_data;
      end else begin
        dccm_rden       = 1'b1;
        dccm_rd_addr_lo = head_addr;
        dccm_rd_addr_hi = head_addr;
      end
    end
  end

  always_comb begin
    rd_pend_d  = dccm_rden;
    rd_owner_d = rd_owner_q;
    if (dccm_rden) rd_owner_d = grant_dma ? DMA : CORE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q   <= '0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= CORE;
    end else begin
      starve_q   <= starve_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  assign core_rd_valid   = rd_pend_q & (rd_owner_q == CORE);
  assign dma_rd_valid    = rd_pend_q & (rd_owner_q == DMA);
  assign core_rd_data_lo = core_rd_valid ? dccm_rd_data_lo : '0;
  assign core_rd_data_hi = core_rd_valid ? dccm_rd_data_hi : '0;
  assign dma_rd_data     = dma_rd_valid ? dccm_rd_data_lo : '0;

endmodule

// File: tb/tb_el2_lsu_dccm_arb.sv
// Directed bench for the DCCM arbiter; read responses are predicted at grant
// time into a scoreboard queue and matched against the DUT every cycle.
module tb_el2_lsu_dccm_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req_valid, core_req_wr;
  logic [15:0] core_addr_lo, core_addr_hi;
  logic [38:0] core_wr_data_lo, core_wr_data_hi;
  logic        core_req_ready;
  logic        dma_req_valid, dma_req_wr;
  logic [15:0] dma_addr;
  logic [38:0] dma_wr_data;
  logic        dma_req_ready;
  logic        dccm_wren, dccm_rden;
  logic [15:0] dccm_wr_addr_lo, dccm_wr_addr_hi, dccm_rd_addr_lo, dccm_rd_addr_hi;
  logic [38:0] dccm_wr_data_lo, dccm_wr_data_hi;
  logic [38:0] dccm_rd_data_lo, dccm_rd_data_hi;
  logic        core_rd_valid, dma_rd_valid;
  logic [38:0] core_rd_data_lo, core_rd_data_hi, dma_rd_data;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    int          due;
    bit          dma;
    logic [38:0] lo;
    logic [38:0] hi;
  } rsp_t;
  rsp_t sb[$];

  el2_lsu_dccm_arb dut (
    .clk(clk), .rst(rst),
    .core_req_valid(core_req_valid), .core_req_wr(core_req_wr),
    .core_addr_lo(core_addr_lo), .core_addr_hi(core_addr_hi),
    .core_wr_data_lo(core_wr_data_lo), .core_wr_data_hi(core_wr_data_hi),
    .core_req_ready(core_req_ready),
    .dma_req_valid(dma_req_valid), .dma_req_wr(dma_req_wr),
    .dma_addr(dma_addr), .dma_wr_data(dma_wr_data), .dma_req_ready(dma_req_ready),
    .dccm_wren(dccm_wren), .dccm_rden(dccm_rden),
    .dccm_wr_addr_lo(dccm_wr_addr_lo), .dccm_wr_addr_hi(dccm_wr_addr_hi),
    .dccm_rd_addr_lo(dccm_rd_addr_lo), .dccm_rd_addr_hi(dccm_rd_addr_hi),
    .dccm_wr_data_lo(dccm_wr_data_lo), .dccm_wr_data_hi(dccm_wr_data_hi),
    .dccm_rd_data_lo(dccm_rd_data_lo), .dccm_rd_data_hi(dccm_rd_data_hi),
    .core_rd_valid(core_rd_valid),
    .core_rd_data_lo(core_rd_data_lo), .core_rd_data_hi(core_rd_data_hi),
    .dma_rd_valid(dma_rd_valid), .dma_rd_data(dma_rd_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [38:0] mdata(logic [15:0] a);
    return {7'h35, a ^ 16'hA5C3, a};
  endfunction

  // Memory model: data for the address read one cycle earlier.
  always @(posedge clk) begin
    dccm_rd_data_lo <= dccm_rden ? mdata(dccm_rd_addr_lo) : 39'h0;
    dccm_rd_data_hi <= dccm_rden ? mdata(dccm_rd_addr_hi) : 39'h0;
  end

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic expect_rsp(bit is_dma, logic [15:0] lo, logic [15:0] hi);
    rsp_t r;
    r.due = cyc + 1;
    r.dma = is_dma;
    r.lo  = mdata(lo);
    r.hi  = mdata(hi);
    sb.push_back(r);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    core_req_valid = 0; core_req_wr = 0;
    core_addr_lo = 0; core_addr_hi = 0;
    core_wr_data_lo = 0; core_wr_data_hi = 0;
    dma_req_valid = 0; dma_req_wr = 0; dma_addr = 0; dma_wr_data = 0;
  endtask

  rsp_t        mon_r;
  logic        mon_ec, mon_ed;
  logic [38:0] mon_lo, mon_hi;
  always @(negedge clk) begin
    if (!rst) begin
      mon_ec = 0; mon_ed = 0; mon_lo = 0; mon_hi = 0;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        mon_r  = sb.pop_front();
        mon_ec = !mon_r.dma;
        mon_ed = mon_r.dma;
        mon_lo = mon_r.lo;
        mon_hi = mon_r.hi;
      end
      check("core_rd_valid", core_rd_valid, mon_ec);
      check("core_rd_data_lo", core_rd_data_lo, mon_ec ? mon_lo : 39'h0);
      check("core_rd_data_hi", core_rd_data_hi, mon_ec ? mon_hi : 39'h0);
      check("dma_rd_valid", dma_rd_valid, mon_ed);
      check("dma_rd_data", dma_rd_data, mon_ed ? mon_lo : 39'h0);
    end
  end

  initial begin
    rst = 1;
    idle_inputs();
    #3;
    check("rst dma_req_ready", dma_req_ready, 1);
    check("rst core_req_ready", core_req_ready, 0);
    check("rst rden", dccm_rden, 0);
    check("rst wren", dccm_wren, 0);
    check("rst core_rd_valid", core_rd_valid, 0);
    check("rst dma_rd_valid", dma_rd_valid, 0);
    step(); step();
    rst = 0;

    // Idle core read
    step();
    core_req_valid = 1; core_addr_lo = 16'h0010; core_addr_hi = 16'h0010;
    #3;
    check("rd core_req_ready", core_req_ready, 1);
    check("rd rden", dccm_rden, 1);
    check("rd wren", dccm_wren, 0);
    check("rd addr_lo", dccm_rd_addr_lo, 16'h0010);
    check("rd addr_hi", dccm_rd_addr_hi, 16'h0010);
    check("rd wr_addr_lo unused", dccm_wr_addr_lo, 0);
    expect_rsp(0, 16'h0010, 16'h0010);

    // Unaligned core write
    step();
    core_req_wr = 1; core_addr_lo = 16'h0014; core_addr_hi = 16'h0018;
    core_wr_data_lo = 39'h11; core_wr_data_hi = 39'h22;
    #3;
    check("wr wren", dccm_wren, 1);
    check("wr rden", dccm_rden, 0);
    check("wr addr_lo", dccm_wr_addr_lo, 16'h0014);
    check("wr addr_hi", dccm_wr_addr_hi, 16'h0018);
    check("wr data_lo", dccm_wr_data_lo, 39'h11);
    check("wr data_hi", dccm_wr_data_hi, 39'h22);
    check("wr rd_addr_lo unused", dccm_rd_addr_lo, 0);

    // Unaligned core read: hi half returns independent data
    step();
    core_req_wr = 0; core_wr_data_lo = 0; core_wr_data_hi = 0;
    core_addr_lo = 16'h001C; core_addr_hi = 16'h0020;
    #3;
    check("ura addr_hi", dccm_rd_addr_hi, 16'h0020);
    expect_rsp(0, 16'h001C, 16'h0020);
    step();
    idle_inputs();
    #3;
    check("idle rden", dccm_rden, 0);
    check("idle wren", dccm_wren, 0);

    // Starvation: core held valid, one DMA read queued per round
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 6; k++) begin
        logic [15:0] ca, da;
        step();
        ca = 16'h0200 + 16'(r * 32 + k * 4);
        da = 16'h0100 + 16'(r * 4);
        core_req_valid = 1; core_addr_lo = ca; core_addr_hi = ca;
        dma_req_valid = (k == 0); dma_req_wr = 0; dma_addr = da;
        #3;
        check("stv rden", dccm_rden, 1);
        if (k == 0) check("stv dma_req_ready", dma_req_ready, 1);
        if (k < 5) begin
          check("stv core_req_ready", core_req_ready, 1);
          check("stv core addr", dccm_rd_addr_lo, ca);
          expect_rsp(0, ca, ca);
        end else begin
          check("stv forced core_req_ready", core_req_ready, 0);
          check("stv dma addr_lo", dccm_rd_addr_lo, da);
          check("stv dma addr_hi", dccm_rd_addr_hi, da);
          expect_rsp(1, da, da);
        end
      end
    end
    step();
    idle_inputs();

    // Fill the FIFO behind core traffic, then drain in order
    step();
    core_req_valid = 1; core_addr_lo = 16'h0280; core_addr_hi = 16'h0280;
    dma_req_valid = 1; dma_addr = 16'h0300;
    #3;
    check("fill0 dma_req_ready", dma_req_ready, 1);
    check("fill0 core_req_ready", core_req_ready, 1);
    expect_rsp(0, 16'h0280, 16'h0280);
    step();
    core_addr_lo = 16'h0284; core_addr_hi = 16'h0284; dma_addr = 16'h0304;
    #3;
    check("fill1 dma_req_ready", dma_req_ready, 1);
    check("fill1 core_req_ready", core_req_ready, 1);
    expect_rsp(0, 16'h0284, 16'h0284);
    step();
    core_req_valid = 0; core_addr_lo = 0; core_addr_hi = 0; dma_addr = 16'h0308;
    #3;
    check("full dma_req_ready", dma_req_ready, 0);
    check("full pop addr", dccm_rd_addr_lo, 16'h0300);
    expect_rsp(1, 16'h0300, 16'h0300);
    step();
    #3;
    check("after pop dma_req_ready", dma_req_ready, 1);
    check("2nd pop addr", dccm_rd_addr_lo, 16'h0304);
    expect_rsp(1, 16'h0304, 16'h0304);
    step();
    dma_req_valid = 0; dma_addr = 0;
    #3;
    check("3rd pop addr", dccm_rd_addr_lo, 16'h0308);
    check("3rd pop rden", dccm_rden, 1);
    expect_rsp(1, 16'h0308, 16'h0308);
    step();
    #3;
    check("drained rden", dccm_rden, 0);

    // Alternating core read / DMA read
    for (int i = 0; i < 4; i++) begin
      logic [15:0] ca, da;
      ca = 16'h0400 + 16'(i * 8);
      da = 16'h0500 + 16'(i * 8);
      step();
      core_req_valid = 1; core_addr_lo = ca; core_addr_hi = ca;
      dma_req_valid = 1; dma_addr = da;
      #3;
      check("alt core addr", dccm_rd_addr_lo, ca);
      expect_rsp(0, ca, ca);
      step();
      idle_inputs();
      #3;
      check("alt dma addr", dccm_rd_addr_lo, da);
      check("alt dma core_req_ready", core_req_ready, 0);
      expect_rsp(1, da, da);
    end

    // DMA write drives both halves
    step();
    dma_req_valid = 1; dma_req_wr = 1; dma_addr = 16'h0600; dma_wr_data = 39'h4A_1234_5678;
    step();
    idle_inputs();
    #3;
    check("dwr wren", dccm_wren, 1);
    check("dwr addr_lo", dccm_wr_addr_lo, 16'h0600);
    check("dwr addr_hi", dccm_wr_addr_hi, 16'h0600);
    check("dwr data_lo", dccm_wr_data_lo, 39'h4A_1234_5678);
    check("dwr data_hi", dccm_wr_data_hi, 39'h4A_1234_5678);

    // Reset with a full FIFO and a read in flight
    step();
    core_req_valid = 1; core_addr_lo = 16'h0700; core_addr_hi = 16'h0700;
    dma_req_valid = 1; dma_req_wr = 0; dma_addr = 16'h0710;
    expect_rsp(0, 16'h0700, 16'h0700);
    step();
    core_addr_lo = 16'h0704; core_addr_hi = 16'h0704; dma_addr = 16'h0714;
    expect_rsp(0, 16'h0704, 16'h0704);
    step();
    idle_inputs();
    check("pre-rst full", dma_req_ready, 0);
    rst = 1;
    sb.delete();
    #1;
    check("rst dma_req_ready", dma_req_ready, 1);
    check("rst rden", dccm_rden, 0);
    check("rst wren", dccm_wren, 0);
    check("rst core_rd_valid", core_rd_valid, 0);
    check("rst core_rd_data_lo", core_rd_data_lo, 0);
    check("rst dma_rd_valid", dma_rd_valid, 0);
    step();
    rst = 0;
    #3;
    check("post-rst dma_req_ready", dma_req_ready, 1);
    check("post-rst rden", dccm_rden, 0);
    check("post-rst wren", dccm_wren, 0);
    step(); step();
    #3;
    check("scoreboard drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
